rbcp_reg_responder: RTL and testbench
=====================================

# rbcp_reg_responder

Local-bus responder for the SiTCP RBCP (UDP register access) port. It decodes byte-wide write and read strobes issued by the SiTCP core and maps them onto a read/write configuration register bank and a read-only status window. It returns one acknowledge per byte, with the read data valid in the acknowledge cycle. It sits between the SiTCP wrapper's RBCP port and the detector-side control logic, in the 125 MHz SiTCP clock domain.

## Interface

Parameters:
- BASE_ADDR, 32'h0000_0000, RBCP address of register offset 0
- NUM_RW, 16, number of read/write byte registers (1..128)
- NUM_RO, 8, number of read-only status bytes (1..128)
- RO_OFFSET, 8'h80, offset of the first read-only byte; must be >= NUM_RW
- ACK_DELAY, 1, cycles from strobe capture to ACK (1..15)

Ports:
- CLK  in  1  system clock, 125 MHz; same domain as the SiTCP core
- RSTn  in  1  reset; one clock, asynchronous assert, active-low
- RBCP_ACT  in  1  transaction active from SiTCP
- RBCP_ADDR  in  32  byte address; valid with WE/RE
- RBCP_WE  in  1  write strobe, one cycle per byte
- RBCP_WD  in  8  write data; valid with WE
- RBCP_RE  in  1  read strobe, one cycle per byte
- RBCP_ACK  out  1  access acknowledge, one-cycle pulse
- RBCP_RD  out  8  read data; valid only while ACK=1, otherwise 0
- STATUS_IN  in  8*NUM_RO  read-only bytes; byte k is at STATUS_IN[8k+7:8k]
- REG_OUT  out  8*NUM_RW  register bank; byte k is at REG_OUT[8k+7:8k]
- REG_WSTB  out  NUM_RW  per-register write pulse, coincident with ACK
- ERR_CNT  out  8  saturating count of rejected accesses

## Operation

- Offset decode: off = RBCP_ADDR - BASE_ADDR, as 32-bit unsigned arithmetic with wrap-around. An address below BASE_ADDR therefore gives a large offset and is unmapped.
  - RW hit: off < NUM_RW.
  - RO hit: RO_OFFSET <= off < RO_OFFSET+NUM_RO.
  - Every other offset is unmapped.
- States: IDLE, WAIT, ACK.
- IDLE
  - A strobe (WE or RE) with ACT=1 captures the address, data, operation and decoded index.
  - For a read, the strobe edge also snapshots the addressed byte (RW register or STATUS_IN).
  - A mapped access goes to WAIT if ACK_DELAY>1, or directly to ACK if ACK_DELAY=1.
  - An unmapped access stays in IDLE, issues no ACK (the host sees a bus error) and increments ERR_CNT.
- WAIT
  - Counts down ACK_DELAY-1 cycles, then goes to ACK.
- ACK
  - ACK=1 for exactly one cycle.
  - Read: RD = the snapshot byte.
  - Write: REG_OUT byte[idx] takes the captured data on the same edge that raises ACK, and REG_WSTB[idx]=1 in that cycle.
  - A write to an RO offset is acked and discarded; no register changes.
  - Always returns to IDLE.
- Simultaneous WE and RE: treated as a write. No error is counted.
- Strobe in WAIT or ACK (protocol violation): the strobe is ignored, ERR_CNT increments, and the transaction in progress continues.
- Strobe with ACT=0: ignored and not counted.
- ACT falls in WAIT or ACK: the FSM aborts to IDLE. No ACK is issued, no write commits and ERR_CNT is unchanged.
- Multi-byte RBCP accesses arrive as a sequence of single-byte strobes with incrementing addresses. Each byte is decoded, snapshotted and acked independently.
- ERR_CNT saturates at 8'hFF. It clears only on reset.

## Timing

- Reset values, asserted asynchronously while RSTn=0:
  - ACK=0, RD=8'h00, REG_OUT all 0, REG_WSTB all 0, ERR_CNT=0, FSM in IDLE.
- Reset is released synchronously, on the first CLK edge after RSTn rises.
- Latency: a strobe sampled at edge n gives ACK=1 in the cycle after edge n+ACK_DELAY-1. With ACK_DELAY=1, ACK is high in the cycle immediately after the strobe cycle.
- The earliest accepted next strobe is in the cycle after ACK. That gives a back-to-back throughput of 1 byte per ACK_DELAY+1 cycles.
- RBCP_RD, RBCP_ACK and REG_WSTB are driven directly from flops. They have no combinational path from the inputs.
- A STATUS_IN change after the capture edge does not affect RD for that access.
- RW read-after-write: a read strobe in the cycle after a write ACK returns the new value.

## Test plan

- Reset: hold RSTn=0 with active strobes present.
  - Required: ACK=0, RD=0, REG_OUT=0, ERR_CNT=0 for the whole reset, then no spurious ACK after release.
- Single write, ACK_DELAY=1, BASE_ADDR=32'h1000: WE with ADDR=32'h1003, WD=8'hA5.
  - Required: ACK one cycle later, REG_OUT[31:24]=8'hA5 and REG_WSTB=16'h0008 for that cycle only.
- RO read: STATUS_IN byte1=8'h5C, RE with ADDR=32'h1081.
  - Required: RD=8'h5C during the single ACK cycle and RD=0 either side of it.
  - Changing STATUS_IN one cycle after the strobe does not alter RD.
- Burst: four writes at 32'h1000..32'h1003 (11,22,33,44), then four reads.
  - Required: 8 ACKs and read data 11,22,33,44.
  - With ACK_DELAY=4, the spacing between consecutive ACKs is 5 cycles.
- Errors:
  - ADDR=32'h1040 gives no ACK and ERR_CNT=1.
  - ADDR=32'h0FFF gives ERR_CNT=2.
  - A strobe during WAIT gives ERR_CNT=3, and the original access still acks.
  - 300 unmapped strobes saturate ERR_CNT at 8'hFF.
- Abort and reset, ACK_DELAY=4:
  - Drop ACT two cycles after a write strobe. Required: no ACK, register unchanged, FSM accepts the next strobe normally.
  - Pulse RSTn low in WAIT. Required: outputs clear immediately without waiting for a clock edge.

Source files
------------

// File: rtl/rbcp_reg_responder.sv
// SiTCP RBCP local-bus responder: byte-wide RW register bank plus RO status window,
// one registered acknowledge per byte with a programmable strobe-to-ACK delay.
module rbcp_reg_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned NUM_RW    = 16,
    parameter int unsigned NUM_RO    = 8,
    parameter int unsigned RO_OFFSET = 8'h80,
    parameter int unsigned ACK_DELAY = 1
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  RBCP_ACT,
    input  logic [31:0]           RBCP_ADDR,
    input  logic                  RBCP_WE,
    input  logic [7:0]            RBCP_WD,
    input  logic                  RBCP_RE,
    output logic                  RBCP_ACK,
    output logic [7:0]            RBCP_RD,
    input  logic [8*NUM_RO-1:0]   STATUS_IN,
    output logic [8*NUM_RW-1:0]   REG_OUT,
    output logic [NUM_RW-1:0]     REG_WSTB,
    output logic [7:0]            ERR_CNT
);

    localparam int unsigned IDX_W     = 7;
    localparam logic [3:0]  WAIT_LOAD = 4'((ACK_DELAY > 1) ? (ACK_DELAY - 2) : 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t           state;
    logic [31:0]      off;
    logic             rw_hit;
    logic             ro_hit;
    logic             strobe;
    logic             accept;
    logic [IDX_W-1:0] rw_idx;
    logic [IDX_W-1:0] ro_idx;
    logic [7:0]       live_byte;

    logic             cap_write;
    logic             cap_ro;
    logic [IDX_W-1:0] cap_idx;
    logic [7:0]       cap_wd;
    logic [7:0]       cap_snap;
    logic [3:0]       wait_cnt;
    logic [7:0]       regs [NUM_RW];

    logic             fire;
    logic             fire_write;
    logic             fire_ro;
    logic [IDX_W-1:0] fire_idx;
    logic [7:0]       fire_wd;
    logic [7:0]       fire_rd;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Offset wraps modulo 2^32, so addresses below the base land far out of range.
    assign off    = RBCP_ADDR - BASE_ADDR;
    assign rw_hit = (off < NUM_RW);
    assign ro_hit = (off >= RO_OFFSET) && (off < RO_OFFSET + NUM_RO);
    assign rw_idx = off[IDX_W-1:0];
    assign ro_idx = IDX_W'(off - RO_OFFSET);
    assign strobe = RBCP_WE | RBCP_RE;
    assign accept = (state == S_IDLE) && RBCP_ACT && strobe && (rw_hit || ro_hit);

    always_comb begin
        live_byte = '0;
        for (int unsigned k = 0; k < NUM_RW; k++)
            if (rw_hit && (32'(rw_idx) == k)) live_byte = regs[k];
        for (int unsigned k = 0; k < NUM_RO; k++)
            if (ro_hit && (32'(ro_idx) == k)) live_byte = STATUS_IN[8*k +: 8];
    end

    // With a one-cycle delay the ACK edge is the strobe edge itself, so the live
    // decode feeds the commit path; otherwise the captured transaction does.
    always_comb begin
        if (ACK_DELAY == 1) begin
            fire       = accept;
            fire_write = RBCP_WE;
            fire_ro    = ro_hit;
            fire_idx   = rw_idx;
            fire_wd    = RBCP_WD;
            fire_rd    = RBCP_WE ? 8'h00 : live_byte;
        end else begin
            fire       = (state == S_WAIT) && RBCP_ACT && (wait_cnt == '0);
            fire_write = cap_write;
            fire_ro    = cap_ro;
            fire_idx   = cap_idx;
            fire_wd    = cap_wd;
            fire_rd    = cap_snap;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            cap_write <= 1'b0;
            cap_ro    <= 1'b0;
            cap_idx   <= '0;
            cap_wd    <= '0;
            cap_snap  <= '0;
            RBCP_ACK  <= 1'b0;
            RBCP_RD   <= '0;
            REG_WSTB  <= '0;
            ERR_CNT   <= '0;
            for (int unsigned k = 0; k < NUM_RW; k++) regs[k] <= '0;
        end else begin
            RBCP_ACK <= fire;
            RBCP_RD  <= fire ? fire_rd : 8'h00;
            REG_WSTB <= '0;
            if (fire && fire_write && !fire_ro) begin
                for (int unsigned k = 0; k < NUM_RW; k++) begin
                    if (32'(fire_idx) == k) begin
                        regs[k]     <= fire_wd;
                        REG_WSTB[k] <= 1'b1;
                    end
                end
            end

            case (state)
                S_IDLE: begin
                    if (RBCP_ACT && strobe) begin
                        if (rw_hit || ro_hit) begin
                            cap_write <= RBCP_WE;
                            cap_ro    <= ro_hit;
                            cap_idx   <= rw_idx;
                            cap_wd    <= RBCP_WD;
                            cap_snap  <= RBCP_WE ? 8'h00 : live_byte;
                            wait_cnt  <= WAIT_LOAD;
                            state     <= (ACK_DELAY == 1) ? S_ACK : S_WAIT;
                        end else begin
                            ERR_CNT <= sat_inc(ERR_CNT);
                        end
                    end
                end
                S_WAIT: begin
                    if (!RBCP_ACT) begin
                        state <= S_IDLE;
                    end else begin
                        if (strobe) ERR_CNT <= sat_inc(ERR_CNT);
                        if (wait_cnt == '0) state <= S_ACK;
                        else                wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_ACK: begin
                    state <= S_IDLE;
                    if (RBCP_ACT && strobe) ERR_CNT <= sat_inc(ERR_CNT);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        REG_OUT = '0;
        for (int unsigned k = 0; k < NUM_RW; k++) REG_OUT[8*k +: 8] = regs[k];
    end

endmodule

// File: tb/tb_rbcp_reg_responder.sv
// Randomized bench for rbcp_reg_responder: two instances (ACK_DELAY 1 and 4)
// checked against a transaction-level model of registers, status window and error count.
module tb_rbcp_reg_responder;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int M_NORMAL = 0;
    localparam int M_INJECT = 1;
    localparam int M_ABORT  = 2;
    localparam int M_NOACT  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rstn    [2];
    logic         act     [2];
    logic [31:0]  addr    [2];
    logic         we      [2];
    logic [7:0]   wd      [2];
    logic         re      [2];
    logic         ack     [2];
    logic [7:0]   rd      [2];
    logic [63:0]  status  [2];
    logic [127:0] reg_out [2];
    logic [15:0]  wstb    [2];
    logic [7:0]   err     [2];

    logic [7:0]   m_regs  [2][16];
    logic [7:0]   m_err   [2];

    int n_tests = 0;
    int n_fail  = 0;

    rbcp_reg_responder #(
        .BASE_ADDR(32'h0000_1000), .NUM_RW(16), .NUM_RO(8), .RO_OFFSET(8'h80), .ACK_DELAY(1)
    ) dut_d1 (
        .CLK(clk), .RSTn(rstn[0]), .RBCP_ACT(act[0]), .RBCP_ADDR(addr[0]),
        .RBCP_WE(we[0]), .RBCP_WD(wd[0]), .RBCP_RE(re[0]), .RBCP_ACK(ack[0]),
        .RBCP_RD(rd[0]), .STATUS_IN(status[0]), .REG_OUT(reg_out[0]),
        .REG_WSTB(wstb[0]), .ERR_CNT(err[0])
    );

    rbcp_reg_responder #(
        .BASE_ADDR(32'h0000_1000), .NUM_RW(16), .NUM_RO(8), .RO_OFFSET(8'h80), .ACK_DELAY(4)
    ) dut_d4 (
        .CLK(clk), .RSTn(rstn[1]), .RBCP_ACT(act[1]), .RBCP_ADDR(addr[1]),
        .RBCP_WE(we[1]), .RBCP_WD(wd[1]), .RBCP_RE(re[1]), .RBCP_ACK(ack[1]),
        .RBCP_RD(rd[1]), .STATUS_IN(status[1]), .REG_OUT(reg_out[1]),
        .REG_WSTB(wstb[1]), .ERR_CNT(err[1])
    );

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [127:0] model_bank(input int u);
        logic [127:0] v;
        for (int k = 0; k < 16; k++) v[8*k +: 8] = m_regs[u][k];
        return v;
    endfunction

    task automatic model_clear(input int u);
        for (int k = 0; k < 16; k++) m_regs[u][k] = 8'h00;
        m_err[u] = 8'h00;
    endtask

    task automatic model_err_inc(input int u);
        if (m_err[u] != 8'hFF) m_err[u] = m_err[u] + 8'd1;
    endtask

    // One byte access, started on a falling edge; ends on the first edge where
    // the next strobe may legally be presented.
    task automatic txn(input int u, input bit w, input bit r, input logic [31:0] a,
                       input logic [7:0] d, input int mode_in);
        logic [31:0] off;
        bit          rw_hit, ro_hit, mapped, exp_ack, commit;
        logic [7:0]  exp_rd;
        int          dly, mode;
        dly    = (u == 0) ? 1 : 4;
        mode   = mode_in;
        off    = a - BASE;
        rw_hit = (off < 32'd16);
        ro_hit = (off >= 32'h80) && (off < 32'h88);
        mapped = rw_hit || ro_hit;
        if (!mapped && (mode == M_INJECT || mode == M_ABORT)) mode = M_NORMAL;
        if (mode == M_ABORT && dly < 3) mode = M_NORMAL;
        exp_ack = mapped && (mode != M_NOACT) && (mode != M_ABORT);
        commit  = exp_ack && w && rw_hit;
        exp_rd  = 8'h00;
        if (exp_ack && !w)
            exp_rd = rw_hit ? m_regs[u][off[3:0]] : status[u][8*int'(off[2:0]) +: 8];
        if (mode != M_NOACT && !mapped) model_err_inc(u);
        if (mode == M_INJECT) model_err_inc(u);

        act[u] = (mode != M_NOACT); we[u] = w; re[u] = r; addr[u] = a; wd[u] = d;
        for (int k = 1; k <= dly + 1; k++) begin
            @(negedge clk);
            if (k == dly && exp_ack) begin
                if (commit) m_regs[u][off[3:0]] = d;
                check_val("ack_pulse", ack[u], 1'b1);
                check_val("ack_rd", rd[u], exp_rd);
                check_val("ack_wstb", wstb[u], commit ? 16'(16'h1 << off[3:0]) : 16'h0);
                check_val("ack_reg_out", reg_out[u], model_bank(u));
            end else begin
                check_val("idle_ack", ack[u], 1'b0);
                check_val("idle_rd", rd[u], 8'h00);
                check_val("idle_wstb", wstb[u], 16'h0);
            end
            if (k == 1) begin
                we[u] = 1'b0; re[u] = 1'b0;
                status[u] = {$urandom, $urandom};
                if (mode == M_INJECT) begin
                    we[u] = 1'($urandom); re[u] = ~we[u];
                    addr[u] = BASE + 32'h40; wd[u] = 8'($urandom);
                end
            end
            if (k == 2) begin
                we[u] = 1'b0; re[u] = 1'b0;
                if (mode == M_ABORT) act[u] = 1'b0;
            end
            if (k == dly + 1) act[u] = 1'b1;
        end
        check_val("err_cnt", err[u], m_err[u]);
        check_val("reg_bank", reg_out[u], model_bank(u));
    endtask

    task automatic rand_txn(input int u);
        logic [31:0] a;
        bit          w, r;
        int          mode, sel;
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: a = BASE + $urandom_range(0, 15);
            5, 6:          a = BASE + 32'h80 + $urandom_range(0, 7);
            7:             a = BASE + $urandom_range(16, 32'h7F);
            8:             a = BASE + 32'h88 + $urandom_range(0, 32'hFFFF);
            default:       a = BASE - $urandom_range(1, 32'h1000);
        endcase
        case ($urandom_range(0, 2))
            0:       begin w = 1'b1; r = 1'b0; end
            1:       begin w = 1'b0; r = 1'b1; end
            default: begin w = 1'b1; r = 1'b1; end
        endcase
        sel  = $urandom_range(0, 11);
        mode = (sel == 0) ? M_INJECT : (sel == 1) ? M_ABORT : (sel == 2) ? M_NOACT : M_NORMAL;
        txn(u, w, r, a, 8'($urandom), mode);
    endtask

    task automatic reset_in_wait(input int u);
        txn(u, 1'b1, 1'b0, BASE + 32'd6, 8'h5A, M_NORMAL);
        check_val("pre_rst_reg6", reg_out[u][55:48], 8'h5A);
        we[u] = 1'b1; addr[u] = BASE + 32'd7; wd[u] = 8'hC3;
        @(negedge clk);
        we[u] = 1'b0;
        @(negedge clk);
        check_val("wait_no_ack", ack[u], 1'b0);
        #2 rstn[u] = 1'b0;
        #1;
        model_clear(u);
        check_val("async_rst_ack", ack[u], 1'b0);
        check_val("async_rst_rd", rd[u], 8'h00);
        check_val("async_rst_reg", reg_out[u], 128'h0);
        check_val("async_rst_wstb", wstb[u], 16'h0);
        check_val("async_rst_err", err[u], 8'h00);
        @(negedge clk);
        rstn[u] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_val("post_rst_ack", ack[u], 1'b0);
        end
        check_val("post_rst_reg", reg_out[u], 128'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int u = 0; u < 2; u++) begin
            rstn[u] = 1'b0; act[u] = 1'b1; we[u] = 1'b1; re[u] = 1'b1;
            addr[u] = BASE; wd[u] = 8'hFF; status[u] = {$urandom, $urandom};
            model_clear(u);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                check_val("rst_ack", ack[u], 1'b0);
                check_val("rst_rd", rd[u], 8'h00);
                check_val("rst_reg", reg_out[u], 128'h0);
                check_val("rst_err", err[u], 8'h00);
            end
        end
        for (int u = 0; u < 2; u++) begin we[u] = 1'b0; re[u] = 1'b0; end
        @(negedge clk);
        for (int u = 0; u < 2; u++) rstn[u] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) check_val("rel_no_ack", ack[u], 1'b0);
        end

        // single write and RO read on the one-cycle instance
        txn(0, 1'b1, 1'b0, 32'h1003, 8'hA5, M_NORMAL);
        check_val("wr_byte3", reg_out[0][31:24], 8'hA5);
        status[0][15:8] = 8'h5C;
        txn(0, 1'b0, 1'b1, 32'h1081, 8'h00, M_NORMAL);
        status[1][15:8] = 8'h5C;
        txn(1, 1'b0, 1'b1, 32'h1081, 8'h00, M_NORMAL);

        // burst of four writes then four reads on both instances
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 4; i++)
                txn(u, 1'b1, 1'b0, BASE + 32'(i), 8'(8'h11 * (i + 1)), M_NORMAL);
            for (int i = 0; i < 4; i++)
                txn(u, 1'b0, 1'b1, BASE + 32'(i), 8'h00, M_NORMAL);
            check_val("burst_bytes", reg_out[u][31:0], 32'h4433_2211);
        end

        // error sequence on the four-cycle instance
        txn(1, 1'b0, 1'b1, 32'h1040, 8'h00, M_NORMAL);
        check_val("err_unmapped", err[1], 8'd1);
        txn(1, 1'b0, 1'b1, 32'h0FFF, 8'h00, M_NORMAL);
        check_val("err_below_base", err[1], 8'd2);
        txn(1, 1'b0, 1'b1, 32'h1082, 8'h00, M_INJECT);
        check_val("err_in_wait", err[1], 8'd3);

        // abort and strobe-with-ACT-low
        txn(1, 1'b1, 1'b0, BASE + 32'd5, 8'h77, M_ABORT);
        check_val("abort_reg5", reg_out[1][47:40], 8'h00);
        txn(1, 1'b1, 1'b0, BASE + 32'd5, 8'h78, M_NORMAL);
        txn(1, 1'b0, 1'b1, BASE + 32'd5, 8'h00, M_NORMAL);
        txn(0, 1'b1, 1'b0, BASE + 32'd2, 8'h99, M_NOACT);
        txn(0, 1'b1, 1'b1, BASE + 32'h84, 8'h66, M_NORMAL);

        for (int i = 0; i < 150; i++) begin
            rand_txn(0);
            rand_txn(1);
        end

        reset_in_wait(1);
        txn(1, 1'b1, 1'b0, BASE + 32'd15, 8'hE1, M_NORMAL);
        txn(1, 1'b0, 1'b1, BASE + 32'd15, 8'h00, M_NORMAL);

        for (int i = 0; i < 300; i++)
            txn(0, 1'b0, 1'b1, (i % 2 == 0) ? BASE + 32'($urandom_range(16, 32'h7F))
                                            : BASE - 32'($urandom_range(1, 32'hFF)), 8'h00, M_NORMAL);
        check_val("err_saturate", err[0], 8'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
